// File: rtl/vpu_wb_fifo.sv
// Write-back FIFO between the vector ALU and the vector register-file write port.
// Circular buffer of {data, tag, mask}. Head is shown first-word fall-through.
// Status flags come from the registered occupancy only. Error flags are sticky.
module vpu_wb_fifo #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 4,
  parameter int TAG_W    = 5,
  parameter int MASK_W   = DATA_W / 8,
  parameter int AF_LEVEL = DEPTH - 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       enq_valid,
  output logic                       enq_ready,
  input  logic [DATA_W-1:0]          enq_data,
  input  logic [TAG_W-1:0]           enq_tag,
  input  logic [MASK_W-1:0]          enq_mask,
  output logic                       deq_valid,
  input  logic                       deq_ready,
  output logic [DATA_W-1:0]          deq_data,
  output logic [TAG_W-1:0]           deq_tag,
  output logic [MASK_W-1:0]          deq_mask,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       ovf_err,
  output logic                       udf_err
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;
    logic [MASK_W-1:0] mask;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            ovf_q, ovf_d;
  logic            udf_q, udf_d;
  logic            full_w, empty_w;
  logic            enq_fire, deq_fire;

  assign full_w   = (count_q == CW'(DEPTH));
  assign empty_w  = (count_q == '0);
  // enq_ready/deq_valid depend only on registered count, so fires never
  // pass through free space or bypass data within one cycle.
  assign enq_fire = enq_valid & ~full_w;
  assign deq_fire = deq_ready & ~empty_w;

  // Next-state for pointers, occupancy and sticky errors; flush wins over fires.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q | (enq_valid & full_w);
    udf_d    = udf_q | (deq_ready & empty_w);
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq_fire) wr_ptr_d = wr_ptr_q + PW'(1);
      if (deq_fire) rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(enq_fire) - CW'(deq_fire);
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Entry storage; not reset, outputs are gated by empty instead.
  always_ff @(posedge clk) begin
    if (!rst && !flush && enq_fire) begin
      mem_q[wr_ptr_q] <= '{data: enq_data, tag: enq_tag, mask: enq_mask};
    end
  end

  assign enq_ready   = ~full_w;
  assign deq_valid   = ~empty_w;
  assign deq_data    = empty_w ? '0 : mem_q[rd_ptr_q].data;
  assign deq_tag     = empty_w ? '0 : mem_q[rd_ptr_q].tag;
  assign deq_mask    = empty_w ? '0 : mem_q[rd_ptr_q].mask;
  assign count       = count_q;
  assign full        = full_w;
  assign empty       = empty_w;
  assign almost_full = (count_q >= CW'(AF_LEVEL));
  assign ovf_err     = ovf_q;
  assign udf_err     = udf_q;

endmodule

// File: tb/tb_vpu_wb_fifo.sv
// Directed and random checks for vpu_wb_fifo with DEPTH=4, AF_LEVEL=3.
module tb_vpu_wb_fifo;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int TAG_W  = 5;
  localparam int MASK_W = 4;

  logic              clk = 1'b0;
  logic              rst, flush, enq_valid, deq_ready;
  logic [DATA_W-1:0] enq_data;
  logic [TAG_W-1:0]  enq_tag;
  logic [MASK_W-1:0] enq_mask;
  logic              enq_ready, deq_valid;
  logic [DATA_W-1:0] deq_data;
  logic [TAG_W-1:0]  deq_tag;
  logic [MASK_W-1:0] deq_mask;
  logic [2:0]        count;
  logic              full, empty, almost_full, ovf_err, udf_err;

  int checks = 0;
  int passes = 0;

  vpu_wb_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .TAG_W(TAG_W), .MASK_W(MASK_W), .AF_LEVEL(3)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_data(enq_data),
    .enq_tag(enq_tag), .enq_mask(enq_mask),
    .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_data(deq_data),
    .deq_tag(deq_tag), .deq_mask(deq_mask),
    .count(count), .full(full), .empty(empty), .almost_full(almost_full),
    .ovf_err(ovf_err), .udf_err(udf_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    enq_valid = 1'b0; deq_ready = 1'b0; flush = 1'b0;
    enq_data = '0; enq_tag = '0; enq_mask = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic push(input logic [31:0] d, input logic [4:0] t);
    enq_valid = 1'b1; enq_data = d; enq_tag = t; enq_mask = 4'hF;
    tick();
    enq_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (count !== 3'd0) $display("FAIL reset_count got %0d exp 0", count); else passes++;
    checks++; if ({empty, full, almost_full, enq_ready, deq_valid} !== 5'b10010)
      $display("FAIL reset_status got %b exp 10010", {empty, full, almost_full, enq_ready, deq_valid}); else passes++;
    checks++; if ({deq_data, deq_tag, deq_mask} !== '0)
      $display("FAIL reset_deq got %h exp 0", {deq_data, deq_tag, deq_mask}); else passes++;
    checks++; if ({ovf_err, udf_err} !== 2'b00) $display("FAIL reset_err got %b exp 00", {ovf_err, udf_err}); else passes++;
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 4; i++) push(32'h11 * (i + 1), 5'(i + 1));
    checks++; if ({full, enq_ready, count} !== {1'b1, 1'b0, 3'd4})
      $display("FAIL fill_full got full=%b rdy=%b cnt=%0d exp 1 0 4", full, enq_ready, count); else passes++;
    deq_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if ({deq_data, deq_tag} !== {32'h11 * (i + 1), 5'(i + 1)})
        $display("FAIL drain_%0d got %h/%0d exp %h/%0d", i, deq_data, deq_tag, 32'h11 * (i + 1), i + 1); else passes++;
      tick();
    end
    deq_ready = 1'b0;
    checks++; if ({empty, deq_data} !== {1'b1, 32'h0})
      $display("FAIL drain_empty got empty=%b data=%h exp 1 0", empty, deq_data); else passes++;
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 4; i++) push(32'h11 * (i + 1), 5'(i + 1));
    push(32'h55, 5'd9);
    checks++; if ({ovf_err, count} !== {1'b1, 3'd4})
      $display("FAIL ovf got ovf=%b cnt=%0d exp 1 4", ovf_err, count); else passes++;
    deq_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (deq_data !== 32'h11 * (i + 1))
        $display("FAIL ovf_drain_%0d got %h exp %h", i, deq_data, 32'h11 * (i + 1)); else passes++;
      tick();
    end
  endtask

  task automatic test_underflow();
    deq_ready = 1'b1;
    tick();
    deq_ready = 1'b0;
    checks++; if ({udf_err, count} !== {1'b1, 3'd0})
      $display("FAIL udf got udf=%b cnt=%0d exp 1 0", udf_err, count); else passes++;
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) push(32'hA1 + i, 5'd3);
    enq_valid = 1'b1; enq_data = 32'hEE; flush = 1'b1;
    tick();
    idle();
    checks++; if ({count, empty, deq_valid} !== {3'd0, 1'b1, 1'b0})
      $display("FAIL flush_state got cnt=%0d empty=%b dv=%b exp 0 1 0", count, empty, deq_valid); else passes++;
    checks++; if ({ovf_err, udf_err} !== 2'b11)
      $display("FAIL flush_err got %b exp 11", {ovf_err, udf_err}); else passes++;
    tick();
    checks++; if ({deq_valid, deq_data} !== {1'b0, 32'h0})
      $display("FAIL flush_no_ee got dv=%b data=%h exp 0 0", deq_valid, deq_data); else passes++;
    push(32'h77, 5'd7);
    checks++; if ({deq_valid, deq_data, count} !== {1'b1, 32'h77, 3'd1})
      $display("FAIL flush_after got dv=%b data=%h cnt=%0d exp 1 77 1", deq_valid, deq_data, count); else passes++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    push(32'h100, 5'd0);
    push(32'h101, 5'd1);
    for (int i = 0; i < 10; i++) begin
      enq_valid = 1'b1; deq_ready = 1'b1; enq_data = 32'h102 + i; enq_tag = 5'(i + 2);
      checks++; if (deq_data !== 32'h100 + i)
        $display("FAIL b2b_data_%0d got %h exp %h", i, deq_data, 32'h100 + i); else passes++;
      tick();
      checks++; if (count !== 3'd2) $display("FAIL b2b_count_%0d got %0d exp 2", i, count); else passes++;
    end
    enq_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++; if ({deq_data, deq_tag} !== {32'h10A + i, 5'(10 + i)})
        $display("FAIL b2b_tail_%0d got %h/%0d exp %h/%0d", i, deq_data, deq_tag, 32'h10A + i, 10 + i); else passes++;
      tick();
    end
    deq_ready = 1'b0;
    checks++; if (empty !== 1'b1) $display("FAIL b2b_empty got %b exp 1", empty); else passes++;
  endtask

  task automatic test_full_simul();
    do_reset();
    for (int i = 0; i < 4; i++) push(32'h200 + i, 5'd4);
    enq_valid = 1'b1; deq_ready = 1'b1; enq_data = 32'h2AA;
    tick();
    checks++; if (count !== 3'd3) $display("FAIL fullsim_cnt got %0d exp 3", count); else passes++;
    deq_ready = 1'b0;
    tick();
    enq_valid = 1'b0;
    checks++; if (count !== 3'd4) $display("FAIL fullsim_accept got %0d exp 4", count); else passes++;
    deq_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic [31:0] e;
      e = (i < 3) ? 32'h201 + i : 32'h2AA;
      checks++; if (deq_data !== e) $display("FAIL fullsim_drain_%0d got %h exp %h", i, deq_data, e); else passes++;
      tick();
    end
    deq_ready = 1'b0;
  endtask

  task automatic test_almost_full();
    do_reset();
    push(32'h1, 5'd1);
    checks++; if (almost_full !== 1'b0) $display("FAIL af_c1 got %b exp 0", almost_full); else passes++;
    push(32'h2, 5'd2);
    checks++; if (almost_full !== 1'b0) $display("FAIL af_c2 got %b exp 0", almost_full); else passes++;
    push(32'h3, 5'd3);
    checks++; if ({almost_full, count} !== {1'b1, 3'd3})
      $display("FAIL af_c3 got af=%b cnt=%0d exp 1 3", almost_full, count); else passes++;
    deq_ready = 1'b1;
    tick();
    deq_ready = 1'b0;
    checks++; if ({almost_full, count} !== {1'b0, 3'd2})
      $display("FAIL af_back2 got af=%b cnt=%0d exp 0 2", almost_full, count); else passes++;
  endtask

  task automatic test_random();
    logic [31:0] q[$];
    int errs;
    bit ef, df;
    errs = 0;
    do_reset();
    for (int c = 0; c < 1000; c++) begin
      enq_valid = ($urandom_range(0, 99) < 55);
      deq_ready = ($urandom_range(0, 99) < 50);
      enq_data  = $urandom;
      enq_tag   = 5'($urandom);
      enq_mask  = 4'($urandom);
      checks++;
      if (count !== 3'(q.size()) || deq_valid !== (q.size() != 0) || full !== (q.size() == 4) ||
          (q.size() != 0 && deq_data !== q[0]) || (q.size() == 0 && deq_data !== 32'h0)) begin
        if (errs < 10)
          $display("FAIL rand_cyc%0d got cnt=%0d dv=%b data=%h exp cnt=%0d head=%h",
                   c, count, deq_valid, deq_data, q.size(), (q.size() != 0) ? q[0] : 32'h0);
        errs++;
      end else passes++;
      ef = enq_valid && (q.size() < 4);
      df = deq_ready && (q.size() > 0);
      tick();
      if (df) void'(q.pop_front());
      if (ef) q.push_back(enq_data);
    end
    idle();
  endtask

  initial begin
    idle();
    rst = 1'b1;
    test_reset();
    test_fill_drain();
    test_overflow();
    test_underflow();
    test_flush();
    test_back_to_back();
    test_full_simul();
    test_almost_full();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/vpu_wb_fifo.md
# vpu_wb_fifo

Parametrised write-back FIFO between the vector ALU and the vector register-file write port. Buffers ALU results, each tagged with a destination register index and a per-lane byte-enable mask, and presents them to the write-back stage in order. It uses valid/ready handshakes on both sides and provides full/empty/almost-full status, a synchronous flush and sticky overflow/underflow error flags. Ordering is strictly FIFO. Read and write proceed concurrently in the same cycle.

## Interface
- DATA_W, 32: result word width in bits.
- DEPTH, 4: number of entries; power of two, ≥2.
- TAG_W, 5: destination vector-register index width.
- MASK_W, DATA_W/8: byte-enable mask width.
- AF_LEVEL, DEPTH-1: occupancy at or above which `almost_full` asserts; 1..DEPTH.

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous clear of all entries; no reset of error flags.
- enq_valid  in  1  ALU result valid.
- enq_ready  out  1  FIFO can accept; equals !full.
- enq_data  in  DATA_W  ALU result.
- enq_tag  in  TAG_W  destination register index.
- enq_mask  in  MASK_W  byte enables.
- deq_valid  out  1  head entry valid; equals !empty.
- deq_ready  in  1  write-back stage consumes head.
- deq_data  out  DATA_W  head result; 0 when empty.
- deq_tag  out  TAG_W  head tag; 0 when empty.
- deq_mask  out  MASK_W  head mask; 0 when empty.
- count  out  $clog2(DEPTH+1)  current occupancy.
- full, empty, almost_full  out  1 each  status.
- ovf_err, udf_err  out  1 each  sticky error flags.

## Operation
- Storage: circular buffer of DEPTH entries {data, tag, mask}. Read pointer rd_ptr and write pointer wr_ptr are $clog2(DEPTH) bits and wrap naturally modulo DEPTH. Occupancy is held in `count`. Entries are never shifted.
- Enqueue fire = enq_valid & enq_ready: write entry at wr_ptr, wr_ptr+1.
- Dequeue fire = deq_valid & deq_ready: rd_ptr+1. Head outputs come from mem[rd_ptr] (first-word fall-through), gated to 0 when empty.
- count next = count + enq_fire − deq_fire.
- Simultaneous fires:
  - Both fire (0<count<DEPTH): count unchanged.
  - At full, enq_ready=0, so only the dequeue fires. There is no same-cycle pass-through of free space.
  - At empty, deq_valid=0, so only the enqueue fires. There is no bypass; new data is visible at deq_* the next cycle.
- Status:
  - full = (count==DEPTH)
  - empty = (count==0)
  - almost_full = (count ≥ AF_LEVEL)
  - All are derived from registered count; no combinational path from enq_*/deq_ready.
- Errors:
  - ovf_err sets when enq_valid=1 while full. The attempt is ignored; data is dropped and the state is unchanged.
  - udf_err sets when deq_ready=1 while empty.
  - Both flags stay set until rst. flush does not clear them.
- flush has priority over fires that cycle: pointers and count go to 0, and any concurrent enq/deq is discarded. Error detection still evaluates normally in the flush cycle.
- rst has priority over flush. Memory contents are not reset; outputs are gated by empty.

## Timing
- Reset values (cycle after rst high):
  - count=0, rd_ptr=wr_ptr=0, empty=1, full=0.
  - almost_full=0 (AF_LEVEL≥1), enq_ready=1, deq_valid=0, deq_*=0.
  - ovf_err=0, udf_err=0.
- Enqueue-to-visible latency is 1 cycle: data enqueued at edge N into an empty FIFO has deq_valid=1 and deq_data valid after edge N.
- Dequeue takes effect at the edge. The next head appears after that edge, or empty=1.
- Reset or flush asserted mid-stream: takes effect at that edge. In-flight handshakes in that cycle do not complete.
- Pointer wrap: after DEPTH enqueues, wr_ptr returns to 0. full is decided by count, not by pointer equality.

## Test plan
- Reset/fill/drain: rst, then enqueue 0x11,0x22,0x33,0x44 with tags 1–4 (DEPTH=4) → full=1, enq_ready=0, count=4. Drain with deq_ready=1 → deq_data sequence 11,22,33,44 with tags 1–4, then empty=1 and deq_data=0.
- Overflow: enqueue while full with enq_data=0x55 → ovf_err=1, count stays 4, next drained values still 11..44. udf_err check: deq_ready=1 while empty → udf_err=1, count stays 0.
- Simultaneous enq/deq at count=2, held for 10 cycles, values 0x100..0x109 → count stays 2, pointers wrap at least twice, output order is exact.
- Full plus simultaneous deq_ready and enq_valid → only the dequeue fires; count goes 4→3; the enqueue is accepted the following cycle.
- Flush mid-stream at count=3 with enq_valid=1 the same cycle → count=0, empty=1, the enqueued word is never output; error flags are unchanged.
- almost_full with AF_LEVEL=3: count 2→3 asserts almost_full, 3→2 deasserts it. Also drive random valid/ready for 1000 cycles against a scoreboard model, with no mismatches.
